// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: hazard FSM state encoding and forwarding-mux select codes.
// The datapath forwarding mux decodes the same FWD_* constants.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // The younger producer (the REG3 ALU result) wins over the older one (REG4).
    function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
        if (ex_hit)
            return FWD_MEM;
        else if (mem_hit)
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Register-address match against a destination, qualified by the producer's write-valid flag.
module hazard_cmp (
    input  logic [4:0] src,
    input  logic [4:0] dst,
    input  logic       valid,
    output logic       hit
);

    assign hit = valid & (src == dst);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-memory wait,
// registered operand-forwarding selects and a saturating stall-cycle counter.
//
//   state    | meaning
//   RUN      | normal flow; any hazard may be acted on
//   LD_STALL | one bubble was inserted for a load-use; EX now holds that bubble
//   MEM_WAIT | data memory is busy; every wall is frozen
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       id_ra_addr,
    input  logic [4:0]       id_rb_addr,
    input  logic             id_use_ra,
    input  logic             id_use_rb,
    input  logic [4:0]       ex_write_reg_addr,
    input  logic             ex_do_reg_write,
    input  logic             ex_do_dm_read,
    input  logic [4:0]       mem_write_reg_addr,
    input  logic             mem_do_reg_write,
    input  logic             ex_branch_taken,
    input  logic             dm_req,
    input  logic             dm_ready,
    output logic             hold_front,
    output logic             bubble_reg2,
    output logic             flush_reg1,
    output logic             hold_all,
    output logic [1:0]       fwd_ra_sel,
    output logic [1:0]       fwd_rb_sel,
    output logic [CNT_W-1:0] stall_count
);

    ctrl_state_t state;
    ctrl_state_t state_next;

    logic ra_ex_hit;
    logic rb_ex_hit;
    logic ra_mem_hit;
    logic rb_mem_hit;
    logic load_use;
    logic mem_wait;

    hazard_cmp u_ra_ex (
        .src   (id_ra_addr),
        .dst   (ex_write_reg_addr),
        .valid (ex_do_reg_write),
        .hit   (ra_ex_hit)
    );

    hazard_cmp u_rb_ex (
        .src   (id_rb_addr),
        .dst   (ex_write_reg_addr),
        .valid (ex_do_reg_write),
        .hit   (rb_ex_hit)
    );

    hazard_cmp u_ra_mem (
        .src   (id_ra_addr),
        .dst   (mem_write_reg_addr),
        .valid (mem_do_reg_write),
        .hit   (ra_mem_hit)
    );

    hazard_cmp u_rb_mem (
        .src   (id_rb_addr),
        .dst   (mem_write_reg_addr),
        .valid (mem_do_reg_write),
        .hit   (rb_mem_hit)
    );

    assign load_use = ex_do_dm_read & ((id_use_ra & ra_ex_hit) | (id_use_rb & rb_ex_hit));
    assign mem_wait = dm_req & ~dm_ready;

    // MEM_WAIT without a pending wait falls through to the RUN rules, so a
    // hazard that was parked behind the memory access is acted on normally.
    always_comb begin
        hold_front  = 1'b0;
        bubble_reg2 = 1'b0;
        flush_reg1  = 1'b0;
        hold_all    = 1'b0;
        state_next  = RUN;
        if (reset_n) begin
            if (mem_wait) begin
                hold_all   = 1'b1;
                state_next = MEM_WAIT;
            end else if (ex_branch_taken) begin
                flush_reg1  = 1'b1;
                bubble_reg2 = 1'b1;
            end else if (load_use && (state != LD_STALL)) begin
                hold_front  = 1'b1;
                bubble_reg2 = 1'b1;
                state_next  = LD_STALL;
            end
        end
    end

    // State and forwarding selects move on the falling edge, with the pipeline walls.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            fwd_ra_sel  <= FWD_REG;
            fwd_rb_sel  <= FWD_REG;
            stall_count <= '0;
        end else begin
            state <= state_next;
            if (!hold_all) begin
                if (bubble_reg2) begin
                    fwd_ra_sel <= FWD_REG;
                    fwd_rb_sel <= FWD_REG;
                end else begin
                    fwd_ra_sel <= fwd_pick(ra_ex_hit & ~ex_do_dm_read, ra_mem_hit);
                    fwd_rb_sel <= fwd_pick(rb_ex_hit & ~ex_do_dm_read, rb_mem_hit);
                end
            end
            if ((hold_front || hold_all) && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, multi-cycle corner sequences and a
// randomized run against a rule-level reference model; a CNT_W=4 copy shares the stimulus.
module tb_pipeline_ctrl;

    logic       clock = 1'b1;
    logic       reset_n = 1'b0;
    logic [4:0] id_ra_addr = '0, id_rb_addr = '0;
    logic       id_use_ra = 1'b0, id_use_rb = 1'b0;
    logic [4:0] ex_write_reg_addr = '0;
    logic       ex_do_reg_write = 1'b0, ex_do_dm_read = 1'b0;
    logic [4:0] mem_write_reg_addr = '0;
    logic       mem_do_reg_write = 1'b0;
    logic       ex_branch_taken = 1'b0, dm_req = 1'b0, dm_ready = 1'b0;

    logic        hold_front, bubble_reg2, flush_reg1, hold_all;
    logic [1:0]  fwd_ra_sel, fwd_rb_sel;
    logic [15:0] stall_count;
    logic        s_hold_front, s_bubble_reg2, s_flush_reg1, s_hold_all;
    logic [1:0]  s_fwd_ra_sel, s_fwd_rb_sel;
    logic [3:0]  s_stall_count;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pipeline_ctrl u_dut (
        .clock(clock), .reset_n(reset_n),
        .id_ra_addr(id_ra_addr), .id_rb_addr(id_rb_addr),
        .id_use_ra(id_use_ra), .id_use_rb(id_use_rb),
        .ex_write_reg_addr(ex_write_reg_addr), .ex_do_reg_write(ex_do_reg_write),
        .ex_do_dm_read(ex_do_dm_read),
        .mem_write_reg_addr(mem_write_reg_addr), .mem_do_reg_write(mem_do_reg_write),
        .ex_branch_taken(ex_branch_taken), .dm_req(dm_req), .dm_ready(dm_ready),
        .hold_front(hold_front), .bubble_reg2(bubble_reg2), .flush_reg1(flush_reg1),
        .hold_all(hold_all), .fwd_ra_sel(fwd_ra_sel), .fwd_rb_sel(fwd_rb_sel),
        .stall_count(stall_count)
    );

    pipeline_ctrl #(.CNT_W(4)) u_small (
        .clock(clock), .reset_n(reset_n),
        .id_ra_addr(id_ra_addr), .id_rb_addr(id_rb_addr),
        .id_use_ra(id_use_ra), .id_use_rb(id_use_rb),
        .ex_write_reg_addr(ex_write_reg_addr), .ex_do_reg_write(ex_do_reg_write),
        .ex_do_dm_read(ex_do_dm_read),
        .mem_write_reg_addr(mem_write_reg_addr), .mem_do_reg_write(mem_do_reg_write),
        .ex_branch_taken(ex_branch_taken), .dm_req(dm_req), .dm_ready(dm_ready),
        .hold_front(s_hold_front), .bubble_reg2(s_bubble_reg2), .flush_reg1(s_flush_reg1),
        .hold_all(s_hold_all), .fwd_ra_sel(s_fwd_ra_sel), .fwd_rb_sel(s_fwd_rb_sel),
        .stall_count(s_stall_count)
    );

    typedef struct {
        logic [4:0] ra;
        logic       ura;
        logic [4:0] rb;
        logic       urb;
        logic [4:0] exw;
        logic       exwe;
        logic       exld;
        logic [4:0] mw;
        logic       mwe;
        logic       br;
        logic       req;
        logic       rdy;
        logic [3:0] ectl;   // {hold_front, bubble_reg2, flush_reg1, hold_all}
        logic [1:0] efra;
        logic [1:0] efrb;
    } vec_t;

    function automatic vec_t mk(
        input logic [4:0] ra, input logic ura, input logic [4:0] rb, input logic urb,
        input logic [4:0] exw, input logic exwe, input logic exld,
        input logic [4:0] mw, input logic mwe,
        input logic br, input logic req, input logic rdy,
        input logic [3:0] ectl, input logic [1:0] efra, input logic [1:0] efrb);
        vec_t v;
        v.ra = ra; v.ura = ura; v.rb = rb; v.urb = urb;
        v.exw = exw; v.exwe = exwe; v.exld = exld;
        v.mw = mw; v.mwe = mwe;
        v.br = br; v.req = req; v.rdy = rdy;
        v.ectl = ectl; v.efra = efra; v.efrb = efrb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        id_ra_addr = v.ra; id_use_ra = v.ura;
        id_rb_addr = v.rb; id_use_rb = v.urb;
        ex_write_reg_addr = v.exw; ex_do_reg_write = v.exwe; ex_do_dm_read = v.exld;
        mem_write_reg_addr = v.mw; mem_do_reg_write = v.mwe;
        ex_branch_taken = v.br; dm_req = v.req; dm_ready = v.rdy;
    endtask

    // Called just after a falling edge: drive, check control mid-cycle, check state after the edge.
    task automatic cyc(input vec_t v, input int ecnt, input string tag);
        int small_cnt;
        small_cnt = (ecnt > 15) ? 15 : ecnt;
        drive(v);
        @(posedge clock);
        chk({tag, " ctl"}, 32'({hold_front, bubble_reg2, flush_reg1, hold_all}), 32'(v.ectl));
        chk({tag, " small ctl"}, 32'({s_hold_front, s_bubble_reg2, s_flush_reg1, s_hold_all}), 32'(v.ectl));
        @(negedge clock);
        #1;
        chk({tag, " fwd_ra"}, 32'(fwd_ra_sel), 32'(v.efra));
        chk({tag, " fwd_rb"}, 32'(fwd_rb_sel), 32'(v.efrb));
        chk({tag, " stall_count"}, 32'(stall_count), 32'(ecnt));
        chk({tag, " small stall_count"}, 32'(s_stall_count), 32'(small_cnt));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src, input vec_t v);
        if (v.exwe && !v.exld && src == v.exw) return 2'b01;
        if (v.mwe && src == v.mw) return 2'b10;
        return 2'b00;
    endfunction

    vec_t tbl[15];
    vec_t v;
    vec_t mw_v;

    initial begin
        // idx: ra ura rb urb | exw we ld | mw we | br req rdy | ctl fra frb
        tbl[0]  = mk(1,1'b0,2,1'b0, 0,1'b0,1'b0, 0,1'b0, 1'b0,1'b0,1'b0, 4'b0000, 2'b00, 2'b00);
        tbl[1]  = mk(1,1'b1,5,1'b1, 5,1'b1,1'b0, 0,1'b0, 1'b0,1'b0,1'b0, 4'b0000, 2'b00, 2'b01);
        tbl[2]  = mk(7,1'b1,2,1'b1, 9,1'b1,1'b0, 7,1'b1, 1'b0,1'b0,1'b0, 4'b0000, 2'b10, 2'b00);
        tbl[3]  = mk(4,1'b1,4,1'b1, 4,1'b1,1'b0, 4,1'b1, 1'b0,1'b0,1'b0, 4'b0000, 2'b01, 2'b01);
        tbl[4]  = mk(0,1'b1,0,1'b0, 0,1'b1,1'b0, 0,1'b1, 1'b0,1'b0,1'b0, 4'b0000, 2'b01, 2'b01);
        tbl[5]  = mk(3,1'b1,6,1'b1, 3,1'b1,1'b1, 0,1'b0, 1'b0,1'b0,1'b0, 4'b1100, 2'b00, 2'b00);
        tbl[6]  = mk(6,1'b1,3,1'b1, 3,1'b1,1'b1, 3,1'b1, 1'b0,1'b0,1'b0, 4'b1100, 2'b00, 2'b00);
        tbl[7]  = mk(3,1'b0,3,1'b0, 3,1'b1,1'b1, 0,1'b0, 1'b0,1'b0,1'b0, 4'b0000, 2'b00, 2'b00);
        tbl[8]  = mk(3,1'b0,8,1'b0, 3,1'b1,1'b1, 3,1'b1, 1'b0,1'b0,1'b0, 4'b0000, 2'b10, 2'b00);
        tbl[9]  = mk(3,1'b1,0,1'b0, 3,1'b0,1'b1, 0,1'b0, 1'b0,1'b0,1'b0, 4'b0000, 2'b00, 2'b00);
        tbl[10] = mk(5,1'b1,5,1'b1, 5,1'b1,1'b0, 0,1'b0, 1'b1,1'b0,1'b0, 4'b0110, 2'b00, 2'b00);
        tbl[11] = mk(3,1'b1,0,1'b0, 3,1'b1,1'b1, 0,1'b0, 1'b1,1'b0,1'b0, 4'b0110, 2'b00, 2'b00);
        tbl[12] = mk(5,1'b1,5,1'b1, 5,1'b1,1'b0, 0,1'b0, 1'b0,1'b1,1'b0, 4'b0001, 2'b00, 2'b00);
        tbl[13] = mk(3,1'b1,3,1'b1, 3,1'b1,1'b1, 0,1'b0, 1'b1,1'b1,1'b0, 4'b0001, 2'b00, 2'b00);
        tbl[14] = mk(5,1'b1,2,1'b1, 5,1'b1,1'b0, 2,1'b1, 1'b0,1'b1,1'b1, 4'b0000, 2'b01, 2'b10);

        @(negedge clock);
        #1;
        // Reset holds everything at zero even with a wait + branch + load-use presented.
        drive(tbl[13]);
        #1;
        chk("reset ctl", 32'({hold_front, bubble_reg2, flush_reg1, hold_all}), 32'(0));
        chk("reset fwd", 32'({fwd_ra_sel, fwd_rb_sel}), 32'(0));
        chk("reset stall_count", 32'(stall_count), 32'(0));
        @(negedge clock);
        #1;

        for (int i = 0; i < 15; i++) begin
            do_reset();
            cyc(tbl[i], (tbl[i].ectl[3] | tbl[i].ectl[0]) ? 1 : 0, $sformatf("vec%0d", i));
        end

        // Load r3 in EX, ID reads r3: one stall, then the load in MEM forwards from REG4.
        do_reset();
        cyc(mk(3,1'b1,6,1'b0, 3,1'b1,1'b1, 0,1'b0, 1'b0,1'b0,1'b0, 4'b1100, 2'b00, 2'b00), 1, "ldu stall");
        cyc(mk(3,1'b1,6,1'b0, 0,1'b0,1'b0, 3,1'b1, 1'b0,1'b0,1'b0, 4'b0000, 2'b10, 2'b00), 1, "ldu advance");

        // Three wait cycles freeze the selects and add three stall cycles.
        do_reset();
        cyc(tbl[1], 0, "wait setup");
        for (int i = 0; i < 3; i++)
            cyc(mk(1,1'b1,5,1'b1, 9,1'b1,1'b0, 5,1'b1, 1'b0,1'b1,1'b0, 4'b0001, 2'b00, 2'b01),
                i + 1, $sformatf("wait%0d", i));
        cyc(mk(1,1'b1,5,1'b1, 9,1'b1,1'b0, 5,1'b1, 1'b0,1'b1,1'b1, 4'b0000, 2'b00, 2'b10), 3, "wait done");

        // Reset pulsed while waiting abandons the wait at once.
        do_reset();
        cyc(tbl[1], 0, "rst setup");
        cyc(mk(5,1'b1,5,1'b1, 5,1'b1,1'b0, 0,1'b0, 1'b0,1'b1,1'b0, 4'b0001, 2'b00, 2'b01), 1, "rst wait");
        drive(tbl[13]);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst mid ctl", 32'({hold_front, bubble_reg2, flush_reg1, hold_all}), 32'(0));
        chk("rst mid fwd", 32'({fwd_ra_sel, fwd_rb_sel}), 32'(0));
        chk("rst mid stall_count", 32'(stall_count), 32'(0));
        chk("rst mid small stall_count", 32'(s_stall_count), 32'(0));
        reset_n = 1'b1;
        cyc(tbl[5], 1, "rst release");

        // Twenty wait cycles: full-width counter reaches 20, the 4-bit copy stops at 15.
        do_reset();
        for (int i = 0; i < 20; i++)
            cyc(tbl[12], i + 1, $sformatf("sat%0d", i));

        // Randomized run against the rule-level model.
        begin
            bit   after_ld;
            logic [1:0] m_fra, m_frb;
            int   m_cnt;
            logic wait_c, lu, hf, bub, fl, ha;
            after_ld = 1'b0; m_fra = 2'b00; m_frb = 2'b00; m_cnt = 0;
            do_reset();
            for (int n = 0; n < 3000; n++) begin
                v = mk(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 2) == 0),
                       5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 1)),
                       4'b0000, 2'b00, 2'b00);
                wait_c = v.req & ~v.rdy;
                lu = v.exld & v.exwe & ((v.ura & (v.ra == v.exw)) | (v.urb & (v.rb == v.exw)));
                ha = wait_c;
                fl = !wait_c && v.br;
                hf = !wait_c && !v.br && lu && !after_ld;
                bub = fl | hf;
                after_ld = hf;
                if (!ha) begin
                    m_fra = bub ? 2'b00 : ref_fwd(v.ra, v);
                    m_frb = bub ? 2'b00 : ref_fwd(v.rb, v);
                end
                if (hf | ha) m_cnt++;
                v.ectl = {hf, bub, fl, ha};
                v.efra = m_fra;
                v.efrb = m_frb;
                cyc(v, m_cnt, $sformatf("rnd%0d", n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning the stall counter width.
REQ-002 SHALL have port clock  in  1  single clock; all state updates on negedge clock, the same edge as the pipeline walls.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports id_ra_addr, id_rb_addr  in  5 each  ID-stage source register addresses.
REQ-005 SHALL have ports id_use_ra, id_use_rb  in  1 each  ID instruction reads ra / rb.
REQ-006 SHALL have port ex_write_reg_addr  in  5  EX-stage destination register.
REQ-007 SHALL have port ex_do_reg_write  in  1  EX-stage instruction writes the regfile.
REQ-008 SHALL have port ex_do_dm_read  in  1  EX-stage instruction is a load.
REQ-009 SHALL have port mem_write_reg_addr  in  5  MEM-stage destination register.
REQ-010 SHALL have port mem_do_reg_write  in  1  MEM-stage instruction writes the regfile.
REQ-011 SHALL have port ex_branch_taken  in  1  taken branch or jump resolved in EX.
REQ-012 SHALL have port dm_req  in  1  MEM stage is accessing data memory.
REQ-013 SHALL have port dm_ready  in  1  data memory completes the access this cycle.
REQ-014 SHALL have port hold_front  out  1  freeze PC and the REG1 wall.
REQ-015 SHALL have port bubble_reg2  out  1  load a NOP into the REG2 wall: all do_* flags 0.
REQ-016 SHALL have port flush_reg1  out  1  replace the REG1 instruction with a NOP.
REQ-017 SHALL have port hold_all  out  1  freeze every wall.
REQ-018 SHALL have ports fwd_ra_sel, fwd_rb_sel  out  2 each  EX operand source: 00 regfile, 01 REG3 alu_result, 10 REG4 write data, 11 reserved.
REQ-019 SHALL have port stall_count  out  CNT_W  stall-cycle count, saturating.

Function
REQ-020 SHALL implement FSM states RUN, LD_STALL and MEM_WAIT.
REQ-021 SHALL define the load-use hazard as ex_do_dm_read & ex_do_reg_write & ((id_use_ra & id_ra_addr==ex_write_reg_addr) | (id_use_rb & id_rb_addr==ex_write_reg_addr)).
REQ-022 SHALL evaluate events in priority order: mem-wait (dm_req & ~dm_ready), then branch, then load-use.
REQ-023 SHALL, on mem-wait in any state, assert hold_all only (hold_front, bubble_reg2 and flush_reg1 all 0), enter MEM_WAIT, and hold fwd selects.
REQ-024 SHALL, in MEM_WAIT with dm_ready=1, deassert hold_all that same cycle and return to RUN; the pending branch or load-use is then re-evaluated normally.
REQ-025 SHALL, on ex_branch_taken without mem-wait, assert flush_reg1 and bubble_reg2 for one cycle, with no hold_front; this cancels any simultaneous load-use stall.
REQ-026 SHALL, on load-use without branch or mem-wait in RUN, assert hold_front and bubble_reg2 for exactly one cycle and go to LD_STALL.
REQ-027 SHALL, in LD_STALL, deassert the stall outputs and return to RUN; a second load-use is impossible because EX holds a bubble.
REQ-028 SHALL compute hold_front, bubble_reg2, flush_reg1 and hold_all combinationally from state and inputs.
REQ-029 SHALL register fwd_*_sel at each edge where the REG2 wall advances without a bubble: 01 if the source matches ex_write_reg_addr with ex_do_reg_write=1 and the instruction is not a load; else 10 if it matches mem_write_reg_addr with mem_do_reg_write=1; else 00.
REQ-030 SHALL give the EX match priority over the MEM match, and SHALL not give register 0 special treatment.
REQ-031 SHALL register fwd_*_sel=00 when bubble_reg2 is asserted, and SHALL hold fwd_*_sel unchanged when hold_all is asserted.
REQ-032 SHALL increment stall_count on every cycle with hold_front or hold_all asserted, saturating at all-ones.

Reset
REQ-033 SHALL, while reset_n=0, set state to RUN, fwd_ra_sel and fwd_rb_sel to 00, stall_count to 0, and drive all combinational outputs to 0 regardless of inputs.
REQ-034 SHALL, on reset asserted mid-stall or mid-wait, abandon the stall or wait immediately; after release, the first edge behaves as in RUN.

Structure
REQ-035 SHALL take the state encoding (2-bit) and the FWD_REG/FWD_MEM/FWD_WB constants from the shared package pipe_pkg, which is also used by the datapath forwarding mux.
REQ-036 SHALL have one sub-module, hazard_cmp: a combinational 5-bit match with valid qualifier, instantiated per operand and stage.

Verification
REQ-037 SHALL cover: load r3 in EX, ID uses ra=r3 -> one cycle with hold_front=1 and bubble_reg2=1; the next advance registers fwd_ra_sel=10.
REQ-038 SHALL cover: ALU writes r5 in EX, ID uses rb=r5 -> no stall; fwd_rb_sel=01 registered.
REQ-039 SHALL cover: ex_branch_taken=1 coincident with a load-use hazard -> flush_reg1=1 and bubble_reg2=1 with hold_front=0 for one cycle.
REQ-040 SHALL cover: dm_req=1 with dm_ready low for 3 cycles -> hold_all=1 for 3 cycles, stall_count +3, fwd selects unchanged.
REQ-041 SHALL cover: reset_n pulsed low during MEM_WAIT -> outputs 0 immediately and stall_count=0; after release, state is RUN.
REQ-042 SHALL cover: CNT_W=4 with 20 stall cycles -> stall_count saturates at 15.
